mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the multicycle controller's instruction fetch
//  (Fetch state) and its data access (MR/MW states). Arbitrates, latches the winning request, drives
//  the memory for MEM_LAT cycles and returns data with a one-cycle ack. Data wins by default;
//  a starvation counter guarantees forward progress for fetch.

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (fetch, data), the shared memory
// and the arbiter.
//
// Handshake: a requester raises *_req with its address/controls stable and
// holds it until its one-cycle *_ack pulse. Requests are looked at only while
// the arbiter is idle. In the cycle after its ack, a requester drops req or
// presents a new request. *_rdata is valid in the ack cycle and is held
// afterwards. mem_rdata must be valid by the last cycle of mem_en.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          dm_req;
  logic          dm_we;
  logic [3:0]    dm_be;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          grant_id;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_be,
           mem_addr, mem_wdata, busy, grant_id
  );

  // Requester/memory side.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_be,
           mem_addr, mem_wdata, busy, grant_id
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// data access. Data wins by default; after STARVE_MAX consecutive data
// grants with fetch waiting, fetch is forced through. Each transaction is
// IDLE (1 cycle) -> ACCESS (MEM_LAT cycles) -> RESP (1 cycle, ack).
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]       o_dbg_state
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]    r_state;
  logic [LW-1:0] r_lat_cnt;
  logic [SW-1:0] r_starve_cnt;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [3:0]    r_mem_be;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_if_rdata;
  logic          r_if_ack;
  logic [DW-1:0] r_dm_rdata;
  logic          r_dm_ack;
  logic          r_busy;
  logic          r_grant_id;

  logic w_starved;
  logic w_grant_dm;
  logic w_grant_if;

  // Fetch is forced only when it is waiting and data has already had its run.
  assign w_starved  = bus.if_req && (r_starve_cnt == SW'(STARVE_MAX));
  assign w_grant_dm = bus.dm_req && !w_starved;
  assign w_grant_if = bus.if_req && !w_grant_dm;

  // Transaction sequencer: arbitration, latching, memory drive and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_if_ack     <= 1'b0;
      r_dm_rdata   <= '0;
      r_dm_ack     <= 1'b0;
      r_busy       <= 1'b0;
      r_grant_id   <= 1'b0;
    end else begin
      // Acks are single-cycle pulses; only the ACCESS exit sets them.
      r_if_ack <= 1'b0;
      r_dm_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_dm && bus.if_req) begin
            if (r_starve_cnt != SW'(STARVE_MAX)) r_starve_cnt <= r_starve_cnt + 1'b1;
          end else begin
            r_starve_cnt <= '0;
          end
          if (w_grant_dm) begin
            r_state     <= S_ACCESS;
            r_busy      <= 1'b1;
            r_grant_id  <= 1'b1;
            r_mem_en    <= 1'b1;
            r_mem_we    <= bus.dm_we;
            r_mem_be    <= bus.dm_be;
            r_mem_addr  <= bus.dm_addr;
            r_mem_wdata <= bus.dm_wdata;
            r_lat_cnt   <= LW'(MEM_LAT - 1);
          end else if (w_grant_if) begin
            r_state     <= S_ACCESS;
            r_busy      <= 1'b1;
            r_grant_id  <= 1'b0;
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'b1111;
            r_mem_addr  <= bus.if_addr;
            r_mem_wdata <= '0;
            r_lat_cnt   <= LW'(MEM_LAT - 1);
          end
        end
        S_ACCESS: begin
          if (r_lat_cnt == '0) begin
            r_state  <= S_RESP;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (r_grant_id) begin
              r_dm_ack <= 1'b1;
              // A store leaves the previous load data in place.
              if (!r_mem_we) r_dm_rdata <= bus.mem_rdata;
            end else begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= bus.mem_rdata;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_ack    = r_if_ack;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.dm_ack    = r_dm_ack;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;
  assign bus.grant_id  = r_grant_id;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter with MEM_LAT=2, STARVE_MAX=4. A small memory
// model answers reads; each expected completion {owner, rdata} is queued when
// its request is driven and compared when an ack appears.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dbg_state;
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  logic [DW:0] exp_q[$];
  logic [DW-1:0] exp_dm_rdata = '0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    case (a)
      32'h0000_3000: mem_val = 32'h2008_0005;
      32'h0000_1000: mem_val = 32'hCAFE_0001;
      default:       mem_val = a ^ 32'h5A5A_A5A5;
    endcase
  endfunction

  assign bus.mem_rdata = mem_val(bus.mem_addr);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every ack pops one expected completion
  always @(negedge clk) begin
    if (!rst && (bus.if_ack || bus.dm_ack)) begin
      check_eq("ack_exclusive", {63'd0, bus.if_ack && bus.dm_ack}, 64'd0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_ack", 64'd1, 64'd0);
      end else begin
        check_eq("sb_completion", {31'd0, bus.dm_ack, bus.dm_ack ? bus.dm_rdata : bus.if_rdata},
                 {31'd0, exp_q.pop_front()});
      end
    end
    if (!rst && bus.mem_we) check_eq("we_without_en", {63'd0, bus.mem_en}, 64'd1);
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_state"}, {62'd0, dbg_state}, 64'd0);
    check_eq({tag, "_ctl"}, {56'd0, bus.mem_en, bus.mem_we, bus.if_ack, bus.dm_ack, bus.busy,
             bus.grant_id, 2'd0}, 64'd0);
    check_eq({tag, "_be_addr"}, {28'd0, bus.mem_be, bus.mem_addr}, 64'd0);
    check_eq({tag, "_wdata"}, {32'd0, bus.mem_wdata}, 64'd0);
    check_eq({tag, "_rdata"}, {bus.if_rdata, bus.dm_rdata}, 64'd0);
  endtask

  // waits (bounded) for the given ack, checks its cycle, then drops that req
  task automatic wait_ack(input bit is_dm, input int t0, input int exp_c, input string tag);
    int got = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (is_dm ? bus.dm_ack : bus.if_ack) begin
        got = cyc - t0;
        break;
      end
    end
    check_eq(tag, 64'(got), 64'(exp_c));
    if (is_dm) bus.dm_req = 1'b0;
    else bus.if_req = 1'b0;
  endtask

  // driver: one isolated transaction, ack expected in cycle 3
  task automatic do_txn(input bit is_dm, input bit we, input logic [AW-1:0] addr,
                        input logic [3:0] be, input logic [DW-1:0] wdata, input string tag);
    int t0;
    @(posedge clk); #1;
    t0 = cyc;
    if (is_dm) begin
      bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr;
      bus.dm_be = be; bus.dm_wdata = wdata;
      if (!we) exp_dm_rdata = mem_val(addr);
      exp_q.push_back({1'b1, exp_dm_rdata});
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
      exp_q.push_back({1'b0, mem_val(addr)});
    end
    wait_ack(is_dm, t0, 3, tag);
  endtask

  initial begin
    int t0;
    int prev_c;
    int got;
    logic exp_dm;
    logic [AW-1:0] a;
    bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_be = '0; bus.dm_addr = '0; bus.dm_wdata = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // 1: single fetch with per-cycle memory strobe checks
    @(posedge clk); #1;
    t0 = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_3000;
    exp_q.push_back({1'b0, 32'h2008_0005});
    @(negedge clk);
    check_eq("t1_c0_en", {63'd0, bus.mem_en}, 64'd0);
    @(negedge clk);
    check_eq("t1_c1", {30'd0, bus.mem_en, bus.mem_we, bus.mem_addr}, {30'd0, 2'b10, 32'h3000});
    check_eq("t1_c1_be_busy", {59'd0, bus.mem_be, bus.busy}, {59'd0, 4'b1111, 1'b1});
    @(negedge clk);
    check_eq("t1_c2_en", {63'd0, bus.mem_en}, 64'd1);
    @(negedge clk);
    check_eq("t1_c3_ack", {62'd0, bus.if_ack, bus.dm_ack}, {62'd0, 2'b10});
    check_eq("t1_c3_en", {63'd0, bus.mem_en}, 64'd0);
    check_eq("t1_rdata", {32'd0, bus.if_rdata}, {32'd0, 32'h2008_0005});
    bus.if_req = 1'b0;

    // 2: simultaneous requests, data first then fetch
    @(posedge clk); #1;
    t0 = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_3000;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_1000;
    exp_dm_rdata = 32'hCAFE_0001;
    exp_q.push_back({1'b1, 32'hCAFE_0001});
    exp_q.push_back({1'b0, 32'h2008_0005});
    @(negedge clk); @(negedge clk);
    check_eq("t2_grant_id", {63'd0, bus.grant_id}, 64'd1);
    wait_ack(1'b1, t0, 3, "t2_dm_ack_cyc");
    wait_ack(1'b0, t0, 7, "t2_if_ack_cyc");

    // 3: store, mem_we exactly in cycles 1-2, dm_rdata untouched
    @(posedge clk); #1;
    t0 = cyc;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h0000_1004;
    bus.dm_be = 4'b0011; bus.dm_wdata = 32'hDEAD_BEEF;
    exp_q.push_back({1'b1, exp_dm_rdata});
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq($sformatf("t3_we_c%0d", c), {63'd0, bus.mem_we}, {63'd0, c == 1 || c == 2});
      if (c == 1) begin
        check_eq("t3_be", {60'd0, bus.mem_be}, {60'd0, 4'b0011});
        check_eq("t3_addr_wdata", {bus.mem_addr, bus.mem_wdata}, {32'h1004, 32'hDEAD_BEEF});
      end
    end
    check_eq("t3_dm_ack", {63'd0, bus.dm_ack}, 64'd1);
    bus.dm_req = 1'b0; bus.dm_we = 1'b0;

    // 4: fetch held while data keeps requesting: D D D D F D, one per 4 cycles
    bus.if_addr = 32'h0000_3000;
    for (int g = 0; g < 6; g++) begin
      if (g == 4) begin
        exp_q.push_back({1'b0, 32'h2008_0005});
      end else begin
        exp_dm_rdata = mem_val(32'h4000 + 32'(4 * (g > 4 ? g - 1 : g)));
        exp_q.push_back({1'b1, exp_dm_rdata});
      end
    end
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.dm_req = 1'b1; bus.dm_addr = 32'h4000;
    a = 32'h4000;
    prev_c = 0;
    for (int g = 0; g < 6; g++) begin
      got = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (bus.if_ack || bus.dm_ack) begin got = 1; break; end
      end
      check_eq($sformatf("t4_ack_seen_%0d", g), 64'(got), 64'd1);
      exp_dm = (g != 4);
      check_eq($sformatf("t4_owner_%0d", g), {63'd0, bus.dm_ack}, {63'd0, exp_dm});
      if (g > 0) check_eq($sformatf("t4_spacing_%0d", g), 64'(cyc - prev_c), 64'd4);
      prev_c = cyc;
      if (g == 5) begin
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
      end else if (bus.dm_ack) begin
        a = a + 32'd4;
        bus.dm_addr = a;
      end
    end

    // 5: reset in cycle 2 of a store aborts it silently
    @(posedge clk); #1;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h0000_1008;
    bus.dm_be = 4'b1100; bus.dm_wdata = 32'h1234_5678;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    exp_dm_rdata = '0;
    @(negedge clk);
    check_all_zero("t5_after_rst");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq($sformatf("t5_quiet_%0d", c), {62'd0, bus.mem_we, bus.dm_ack}, 64'd0);
    end
    do_txn(1'b0, 1'b0, 32'h0000_3000, 4'b0000, '0, "t5_fetch_ack_cyc");

    // 6: load whose req is dropped in cycle 1 still completes
    @(posedge clk); #1;
    t0 = cyc;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_2000;
    exp_dm_rdata = mem_val(32'h2000);
    exp_q.push_back({1'b1, exp_dm_rdata});
    @(posedge clk); #1;
    bus.dm_req = 1'b0; bus.dm_addr = 32'hFFFF_FFF0;
    wait_ack(1'b1, t0, 3, "t6_dm_ack_cyc");

    // random isolated transactions
    for (int i = 0; i < 10; i++) begin
      logic is_dm;
      logic we;
      is_dm = 1'($urandom_range(0, 1));
      we = is_dm ? 1'($urandom_range(0, 1)) : 1'b0;
      do_txn(is_dm, we, 32'($urandom_range(0, 32'hFFFF)) << 2, 4'($urandom_range(1, 15)),
             32'($urandom), $sformatf("rnd_ack_cyc_%0d", i));
    end

    repeat (3) @(negedge clk);
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
